i2c_reg_sequencer: RTL and testbench

I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

---
 rtl/i2c_reg_sequencer_if.sv | 93 +++++++++
 rtl/i2c_reg_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_sequencer_if.sv
// ---------------------------------------------------------------------------
// i2c_reg_sequencer_if
// Bundles every handshake/stream signal of the register sequencer.
//   slave  modport : seen by the sequencer itself
//   master modport : seen by the environment (requester + I2C master core)
// Signal groups:
//   req_*   request handshake (rw, device, register, byte count)
//   wr_*    write-data stream from the requester
//   rd_*    read-data stream to the requester
//   done_o / err_o   completion pulse and error flag
//   cmd_*   command port of the I2C master core
//   txd_* / rxd_*    transmit / receive byte streams of the master core
//   busy_i / missing_ack_i   master status
// ---------------------------------------------------------------------------
interface i2c_reg_sequencer_if #(
   parameter int LEN_W = 4
);
   logic             req_valid_i;
   logic             req_ready_o;
   logic             req_rw_i;
   logic [6:0]       req_dev_i;
   logic [7:0]       req_reg_i;
   logic [LEN_W-1:0] req_len_i;

   logic [7:0]       wr_data_i;
   logic             wr_valid_i;
   logic             wr_ready_o;

   logic [7:0]       rd_data_o;
   logic             rd_valid_o;
   logic             rd_ready_i;

   logic             done_o;
   logic             err_o;

   logic [6:0]       cmd_address_o;
   logic             cmd_start_o;
   logic             cmd_read_o;
   logic             cmd_write_o;
   logic             cmd_write_multiple_o;
   logic             cmd_stop_o;
   logic             cmd_valid_o;
   logic             cmd_ready_i;

   logic [7:0]       txd_data_o;
   logic             txd_valid_o;
   logic             txd_last_o;
   logic             txd_ready_i;

   logic [7:0]       rxd_data_i;
   logic             rxd_valid_i;
   logic             rxd_last_i;
   logic             rxd_ready_o;

   logic             busy_i;
   logic             missing_ack_i;

   modport slave (
      input  req_valid_i, req_rw_i, req_dev_i, req_reg_i, req_len_i,
      output req_ready_o,
      input  wr_data_i, wr_valid_i,
      output wr_ready_o,
      output rd_data_o, rd_valid_o,
      input  rd_ready_i,
      output done_o, err_o,
      output cmd_address_o, cmd_start_o, cmd_read_o, cmd_write_o,
             cmd_write_multiple_o, cmd_stop_o, cmd_valid_o,
      input  cmd_ready_i,
      output txd_data_o, txd_valid_o, txd_last_o,
      input  txd_ready_i,
      input  rxd_data_i, rxd_valid_i, rxd_last_i,
      output rxd_ready_o,
      input  busy_i, missing_ack_i
   );

   modport master (
      output req_valid_i, req_rw_i, req_dev_i, req_reg_i, req_len_i,
      input  req_ready_o,
      output wr_data_i, wr_valid_i,
      input  wr_ready_o,
      input  rd_data_o, rd_valid_o,
      output rd_ready_i,
      input  done_o, err_o,
      input  cmd_address_o, cmd_start_o, cmd_read_o, cmd_write_o,
             cmd_write_multiple_o, cmd_stop_o, cmd_valid_o,
      output cmd_ready_i,
      input  txd_data_o, txd_valid_o, txd_last_o,
      output txd_ready_i,
      output rxd_data_i, rxd_valid_i, rxd_last_i,
      input  rxd_ready_o,
      output busy_i, missing_ack_i
   );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_reg_sequencer
// Turns one register-level request (write N bytes to reg, or read N bytes
// from reg) into the command/byte sequence of an I2C master core.
// Ports:
//   clk_i  sole clock, rising edge
//   rst_i  asynchronous active-high reset
//   bus    i2c_reg_sequencer_if.slave (request, data streams, master port)
// Write : one write_multiple command (start+stop), then reg byte + data.
// Read  : write command (start, no stop) + reg byte, then one read command
//         per data byte (start on first, stop on last).
// A NACK from the master aborts with a stop-only command and flags err_o.
// ---------------------------------------------------------------------------
module i2c_reg_sequencer #(
   parameter int LEN_W = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   i2c_reg_sequencer_if.slave    bus
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_W_CMD     = 4'd1;
   localparam logic [3:0] S_W_REG     = 4'd2;
   localparam logic [3:0] S_W_DATA    = 4'd3;
   localparam logic [3:0] S_R_CMDW    = 4'd4;
   localparam logic [3:0] S_R_REG     = 4'd5;
   localparam logic [3:0] S_R_CMDR    = 4'd6;
   localparam logic [3:0] S_R_DATA    = 4'd7;
   localparam logic [3:0] S_ABORT     = 4'd8;
   localparam logic [3:0] S_WAIT_IDLE = 4'd9;
   localparam logic [3:0] S_DONE      = 4'd10;

   localparam logic [LEN_W-1:0] LEN_ZERO = '0;
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

   logic [3:0]       state_reg, state_next;
   logic             rw_reg;
   logic [6:0]       dev_reg;
   logic [7:0]       reg_addr_reg;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] cnt_reg;
   logic             err_reg;

   logic             accept;
   logic             cnt_inc;
   logic             at_last;
   logic             abort_now;

   logic             req_ready;
   logic             wr_ready;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic             done;
   logic             err;
   logic [6:0]       cmd_address;
   logic             cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop;
   logic             cmd_valid;
   logic [7:0]       txd_data;
   logic             txd_valid, txd_last;
   logic             rxd_ready;

   // rxd_last_i carries no information beyond our own byte count.
   logic             unused_rxd_last;
   assign unused_rxd_last = bus.rxd_last_i;

   // Counter runs 0..len-1 and is compared against len-1, so it never wraps
   // even for the largest len the field can hold. Only used when len >= 1.
   assign at_last   = (cnt_reg == (len_reg - LEN_ONE));
   // Requests are only accepted once reset has been released.
   assign req_ready = (state_reg == S_IDLE) && !rst_i;
   assign accept    = req_ready && bus.req_valid_i;
   assign abort_now = (state_reg != S_IDLE) && bus.missing_ack_i;

   always_comb begin
      state_next         = state_reg;
      cnt_inc            = 1'b0;
      wr_ready           = 1'b0;
      rd_data            = 8'h00;
      rd_valid           = 1'b0;
      done               = 1'b0;
      err                = 1'b0;
      cmd_address        = 7'h00;
      cmd_start          = 1'b0;
      cmd_read           = 1'b0;
      cmd_write          = 1'b0;
      cmd_write_multiple = 1'b0;
      cmd_stop           = 1'b0;
      cmd_valid          = 1'b0;
      txd_data           = 8'h00;
      txd_valid          = 1'b0;
      txd_last           = 1'b0;
      rxd_ready          = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               if (!bus.req_rw_i)
                  state_next = S_W_CMD;
               else if (bus.req_len_i == LEN_ZERO)
                  state_next = S_DONE;   // nothing to read: report error, no bus traffic
               else
                  state_next = S_R_CMDW;
            end
         end
         S_W_CMD: begin
            cmd_valid          = 1'b1;
            cmd_address        = dev_reg;
            cmd_start          = 1'b1;
            cmd_write_multiple = 1'b1;
            cmd_stop           = 1'b1;
            if (bus.cmd_ready_i) state_next = S_W_REG;
         end
         S_W_REG: begin
            txd_valid = 1'b1;
            txd_data  = reg_addr_reg;
            txd_last  = (len_reg == LEN_ZERO);
            if (bus.txd_ready_i)
               state_next = (len_reg == LEN_ZERO) ? S_WAIT_IDLE : S_W_DATA;
         end
         S_W_DATA: begin
            // Requester bytes pass straight through to the master.
            txd_valid = bus.wr_valid_i;
            txd_data  = bus.wr_data_i;
            txd_last  = at_last;
            wr_ready  = bus.txd_ready_i;
            if (bus.wr_valid_i && bus.txd_ready_i) begin
               if (at_last) state_next = S_WAIT_IDLE;
               else         cnt_inc    = 1'b1;
            end
         end
         S_R_CMDW: begin
            cmd_valid   = 1'b1;
            cmd_address = dev_reg;
            cmd_start   = 1'b1;
            cmd_write   = 1'b1;
            if (bus.cmd_ready_i) state_next = S_R_REG;
         end
         S_R_REG: begin
            txd_valid = 1'b1;
            txd_data  = reg_addr_reg;
            txd_last  = 1'b1;
            if (bus.txd_ready_i) state_next = S_R_CMDR;
         end
         S_R_CMDR: begin
            cmd_valid   = 1'b1;
            cmd_address = dev_reg;
            cmd_read    = 1'b1;
            cmd_start   = (cnt_reg == LEN_ZERO);   // repeated start on first byte only
            cmd_stop    = at_last;
            if (bus.cmd_ready_i) state_next = S_R_DATA;
         end
         S_R_DATA: begin
            // Backpressure from the requester stalls the master, so no byte is lost.
            rd_valid  = bus.rxd_valid_i;
            rd_data   = bus.rxd_data_i;
            rxd_ready = bus.rd_ready_i;
            if (bus.rxd_valid_i && bus.rd_ready_i) begin
               if (at_last) begin
                  state_next = S_WAIT_IDLE;
               end else begin
                  cnt_inc    = 1'b1;
                  state_next = S_R_CMDR;
               end
            end
         end
         S_ABORT: begin
            cmd_valid = 1'b1;
            cmd_stop  = 1'b1;
            if (bus.cmd_ready_i) state_next = S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (!bus.busy_i) state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            err        = err_reg;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase

      // A NACK overrides whatever transition the state would have taken.
      if (abort_now) state_next = S_ABORT;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg    <= S_IDLE;
         rw_reg       <= 1'b0;
         dev_reg      <= 7'h00;
         reg_addr_reg <= 8'h00;
         len_reg      <= LEN_ZERO;
         cnt_reg      <= LEN_ZERO;
         err_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            rw_reg       <= bus.req_rw_i;
            dev_reg      <= bus.req_dev_i;
            reg_addr_reg <= bus.req_reg_i;
            len_reg      <= bus.req_len_i;
            cnt_reg      <= LEN_ZERO;
            err_reg      <= bus.req_rw_i && (bus.req_len_i == LEN_ZERO);
         end else begin
            if (cnt_inc)   cnt_reg <= cnt_reg + LEN_ONE;
            if (abort_now) err_reg <= 1'b1;
         end
      end
   end

   assign bus.req_ready_o          = req_ready;
   assign bus.wr_ready_o           = wr_ready;
   assign bus.rd_data_o            = rd_data;
   assign bus.rd_valid_o           = rd_valid;
   assign bus.done_o               = done;
   assign bus.err_o                = err;
   assign bus.cmd_address_o        = cmd_address;
   assign bus.cmd_start_o          = cmd_start;
   assign bus.cmd_read_o           = cmd_read;
   assign bus.cmd_write_o          = cmd_write;
   assign bus.cmd_write_multiple_o = cmd_write_multiple;
   assign bus.cmd_stop_o           = cmd_stop;
   assign bus.cmd_valid_o          = cmd_valid;
   assign bus.txd_data_o           = txd_data;
   assign bus.txd_valid_o          = txd_valid;
   assign bus.txd_last_o           = txd_last;
   assign bus.rxd_ready_o          = rxd_ready;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_sequencer
// Table of register transactions driven through the sequencer against a
// behavioural I2C master model; expected commands, transmit bytes and read
// bytes are queued when a request is issued and popped as the DUT emits them.
// Hand-written sequences cover NACK abort, requester backpressure and reset
// in the middle of a write.
// ---------------------------------------------------------------------------
module tb_i2c_reg_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   i2c_reg_sequencer_if #(.LEN_W(4)) bus ();

   i2c_reg_sequencer #(.LEN_W(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic [6:0] addr;
      logic       start;
      logic       read;
      logic       write;
      logic       wm;
      logic       stop;
   } cmd_t;

   typedef struct {
      logic       rw;
      logic [6:0] dev;
      logic [7:0] rg;
      logic [3:0] len;
      logic [7:0] data [15];
      logic       exp_err;
   } txn_t;

   int checks = 0;
   int errors = 0;

   cmd_t       exp_cmd_q [$];
   logic [8:0] exp_txd_q [$];
   logic [7:0] exp_rd_q  [$];
   logic [7:0] wr_src_q  [$];
   logic [7:0] rx_src_q  [$];

   int   rx_pending = 0;
   int   busy_cnt   = 0;
   int   rd_stall   = 0;
   int   stall_arm  = 0;
   int   cyc        = 0;
   int   done_cnt   = 0;
   int   acc_cyc    = 0;
   bit   bus_open   = 0;
   bit   txd_hold   = 0;
   bit   ack_arm    = 0;
   bit   req_pend   = 0;
   bit   wr_ready_seen = 0;
   bit   cmd_seen   = 0;
   bit   prev_cmd_wait = 0;
   cmd_t prev_cmd;
   logic [7:0] ack_byte;
   logic last_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h expected nothing", name, act);
   endtask

   function automatic cmd_t cur_cmd();
      return cmd_t'({bus.cmd_address_o, bus.cmd_start_o, bus.cmd_read_o,
                     bus.cmd_write_o, bus.cmd_write_multiple_o, bus.cmd_stop_o});
   endfunction

   // One clock: drive inputs at negedge, sample 1 ns later, posedge commits.
   task automatic cycle();
      bit stalled;
      @(negedge clk);
      cyc++;
      bus.missing_ack_i = 1'b0;
      bus.req_valid_i   = req_pend;
      bus.cmd_ready_i   = ($urandom_range(0, 2) != 0);
      bus.txd_ready_i   = txd_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (stall_arm > 0 && rx_pending > 0 && rx_src_q.size() > 0) begin
         rd_stall  = stall_arm;
         stall_arm = 0;
      end
      stalled = (rd_stall > 0);
      bus.rd_ready_i = stalled ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (rd_stall > 0) rd_stall--;
      if (rx_pending > 0 && rx_src_q.size() > 0) begin
         bus.rxd_valid_i = 1'b1;
         bus.rxd_data_i  = rx_src_q[0];
         bus.rxd_last_i  = 1'b1;
      end else begin
         bus.rxd_valid_i = 1'b0;
         bus.rxd_data_i  = 8'h00;
         bus.rxd_last_i  = 1'b0;
      end
      if (wr_src_q.size() > 0) begin
         bus.wr_valid_i = ($urandom_range(0, 3) != 0);
         bus.wr_data_i  = wr_src_q[0];
      end else begin
         bus.wr_valid_i = 1'b0;
         bus.wr_data_i  = 8'h00;
      end
      bus.busy_i = bus_open || (busy_cnt > 0);
      #1;
      if (ack_arm && bus.txd_valid_o && bus.txd_data_o == ack_byte) begin
         bus.missing_ack_i = 1'b1;
         ack_arm = 0;
      end

      if (prev_cmd_wait)
         chk("cmd_hold", {bus.cmd_valid_o, cur_cmd()}, {1'b1, prev_cmd});
      prev_cmd_wait = bus.cmd_valid_o && !bus.cmd_ready_i;
      prev_cmd      = cur_cmd();

      if (bus.wr_ready_o)  wr_ready_seen = 1;
      if (bus.cmd_valid_o) cmd_seen = 1;
      if (bus.req_valid_i && bus.req_ready_o) begin
         req_pend = 0;
         acc_cyc  = cyc;
      end

      if (bus.cmd_valid_o && bus.cmd_ready_i) begin
         if (exp_cmd_q.size() == 0) unexpected("cmd_extra", 32'(cur_cmd()));
         else chk("cmd", 32'(cur_cmd()), 32'(exp_cmd_q.pop_front()));
         if (bus.cmd_read_o) rx_pending++;
         bus_open = 1;
         if (bus.cmd_stop_o) begin
            bus_open = 0;
            busy_cnt = 3;
         end
      end
      if (bus.txd_valid_o && bus.txd_ready_i) begin
         if (exp_txd_q.size() == 0) unexpected("txd_extra", {bus.txd_last_o, bus.txd_data_o});
         else chk("txd", {bus.txd_last_o, bus.txd_data_o}, 32'(exp_txd_q.pop_front()));
      end
      if (bus.wr_valid_i && bus.wr_ready_o) void'(wr_src_q.pop_front());
      if (stalled && bus.rxd_valid_i) begin
         chk("stall_rxd_ready", bus.rxd_ready_o, 0);
         chk("stall_rd_valid", bus.rd_valid_o, 1);
      end
      if (bus.rxd_valid_i && bus.rxd_ready_o) begin
         void'(rx_src_q.pop_front());
         rx_pending--;
      end
      if (bus.rd_valid_o && bus.rd_ready_i) begin
         if (exp_rd_q.size() == 0) unexpected("rd_extra", bus.rd_data_o);
         else chk("rd_data", bus.rd_data_o, 32'(exp_rd_q.pop_front()));
      end
      if (bus.done_o) begin
         done_cnt++;
         last_err = bus.err_o;
      end
      if (busy_cnt > 0 && !bus_open) busy_cnt--;
   endtask

   task automatic run_txn(input txn_t t, input bit abort);
      int d0;
      int n;
      d0 = done_cnt;
      wr_ready_seen = 0;
      cmd_seen = 0;
      if (!t.rw) begin
         exp_cmd_q.push_back(cmd_t'({t.dev, 5'b10011}));
         for (int i = 0; i < int'(t.len); i++) wr_src_q.push_back(t.data[i]);
         if (abort) begin
            exp_cmd_q.push_back(cmd_t'({7'h00, 5'b00001}));
            txd_hold = 1;
            ack_arm  = 1;
            ack_byte = t.rg;
         end else begin
            exp_txd_q.push_back({t.len == 0, t.rg});
            for (int i = 0; i < int'(t.len); i++)
               exp_txd_q.push_back({i == int'(t.len) - 1, t.data[i]});
         end
      end else if (t.len != 0) begin
         exp_cmd_q.push_back(cmd_t'({t.dev, 5'b10100}));
         exp_txd_q.push_back({1'b1, t.rg});
         for (int i = 0; i < int'(t.len); i++) begin
            exp_cmd_q.push_back(cmd_t'({t.dev, i == 0, 1'b1, 1'b0, 1'b0, i == int'(t.len) - 1}));
            rx_src_q.push_back(t.data[i]);
            exp_rd_q.push_back(t.data[i]);
         end
      end
      bus.req_rw_i  = t.rw;
      bus.req_dev_i = t.dev;
      bus.req_reg_i = t.rg;
      bus.req_len_i = t.len;
      req_pend = 1;
      n = 0;
      while (done_cnt == d0 && n < 800) begin
         cycle();
         n++;
      end
      if (done_cnt == d0) unexpected("done_timeout", n);
      chk("err", last_err, t.exp_err);
      chk("cmd_left", exp_cmd_q.size(), 0);
      chk("txd_left", exp_txd_q.size(), 0);
      chk("rd_left", exp_rd_q.size(), 0);
      if (abort) begin
         chk("abort_wr_left", wr_src_q.size(), t.len);
         chk("abort_wr_ready", wr_ready_seen, 0);
         wr_src_q.delete();
         txd_hold = 0;
      end
      if (t.rw && t.len == 0) begin
         chk("len0_no_cmd", cmd_seen, 0);
         chk("len0_latency", cyc - acc_cyc, 1);
      end
      $display("txn rw=%0d dev=%02h reg=%02h len=%0d abort=%0d err=%0d cycles=%0d",
               t.rw, t.dev, t.rg, t.len, abort, last_err, n);
      exp_cmd_q.delete();
      exp_txd_q.delete();
      exp_rd_q.delete();
      rx_src_q.delete();
      rx_pending = 0;
   endtask

   txn_t tbl [7];
   txn_t t;
   logic [31:0] all_out;

   initial begin
      rst = 1'b1;
      bus.req_valid_i = 0; bus.req_rw_i = 0; bus.req_dev_i = 0; bus.req_reg_i = 0;
      bus.req_len_i = 0; bus.wr_data_i = 0; bus.wr_valid_i = 0; bus.rd_ready_i = 0;
      bus.cmd_ready_i = 0; bus.txd_ready_i = 0; bus.rxd_data_i = 0; bus.rxd_valid_i = 0;
      bus.rxd_last_i = 0; bus.busy_i = 0; bus.missing_ack_i = 0;

      // rw, dev, reg, len, data, expected err
      for (int k = 0; k < 7; k++)
         for (int i = 0; i < 15; i++) tbl[k].data[i] = 8'(k * 37 + i * 19 + 3);
      tbl[0].rw = 0; tbl[0].dev = 7'h50; tbl[0].rg = 8'h10; tbl[0].len = 4'd2;  tbl[0].exp_err = 0;
      tbl[0].data[0] = 8'hA5; tbl[0].data[1] = 8'h5A;
      tbl[1].rw = 1; tbl[1].dev = 7'h50; tbl[1].rg = 8'h20; tbl[1].len = 4'd3;  tbl[1].exp_err = 0;
      tbl[1].data[0] = 8'h11; tbl[1].data[1] = 8'h22; tbl[1].data[2] = 8'h33;
      tbl[2].rw = 1; tbl[2].dev = 7'h3C; tbl[2].rg = 8'h05; tbl[2].len = 4'd0;  tbl[2].exp_err = 1;
      tbl[3].rw = 0; tbl[3].dev = 7'h21; tbl[3].rg = 8'h7F; tbl[3].len = 4'd0;  tbl[3].exp_err = 0;
      tbl[4].rw = 0; tbl[4].dev = 7'h7F; tbl[4].rg = 8'hFF; tbl[4].len = 4'd15; tbl[4].exp_err = 0;
      tbl[5].rw = 1; tbl[5].dev = 7'h12; tbl[5].rg = 8'h00; tbl[5].len = 4'd15; tbl[5].exp_err = 0;
      tbl[6].rw = 1; tbl[6].dev = 7'h01; tbl[6].rg = 8'h80; tbl[6].len = 4'd1;  tbl[6].exp_err = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      all_out = {bus.wr_ready_o, bus.rd_valid_o, bus.done_o, bus.err_o, bus.cmd_valid_o,
                 bus.cmd_start_o, bus.cmd_stop_o, bus.txd_valid_o, bus.txd_last_o,
                 bus.rxd_ready_o, bus.txd_data_o, bus.cmd_address_o};
      chk("reset_outputs", all_out, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_req_ready", bus.req_ready_o, 1);

      for (int k = 0; k < 7; k++) run_txn(tbl[k], 1'b0);

      // NACK while the register byte is on txd
      t = tbl[0];
      t.exp_err = 1;
      run_txn(t, 1'b1);

      // Requester holds rd_ready low for 20 cycles while data is pending
      t = tbl[1];
      t.dev = 7'h44;
      stall_arm = 20;
      run_txn(t, 1'b0);

      // Reset in the middle of W_DATA
      exp_cmd_q.push_back(cmd_t'({7'h33, 5'b10011}));
      exp_txd_q.push_back({1'b0, 8'h44});
      exp_txd_q.push_back({1'b0, 8'h99});
      wr_src_q.push_back(8'h99);
      bus.req_rw_i = 0; bus.req_dev_i = 7'h33; bus.req_reg_i = 8'h44; bus.req_len_i = 4'd4;
      req_pend = 1;
      for (int n = 0; n < 300 && (exp_txd_q.size() != 0 || wr_src_q.size() != 0); n++) cycle();
      chk("mid_write_txd_done", exp_txd_q.size(), 0);
      @(negedge clk);
      bus.wr_valid_i  = 1'b1;
      bus.wr_data_i   = 8'hC3;
      bus.txd_ready_i = 1'b1;
      #1;
      chk("mid_write_passthru", {bus.txd_valid_o, bus.txd_data_o}, {1'b1, 8'hC3});
      rst = 1'b1;
      #1;
      all_out = {bus.req_ready_o, bus.wr_ready_o, bus.rd_valid_o, bus.done_o, bus.err_o,
                 bus.cmd_valid_o, bus.cmd_write_multiple_o, bus.txd_valid_o, bus.txd_last_o,
                 bus.rxd_ready_o, bus.txd_data_o, bus.cmd_address_o};
      chk("midrst_outputs", all_out, 0);
      bus.wr_valid_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus_open = 0; busy_cnt = 0; rx_pending = 0; prev_cmd_wait = 0;
      exp_cmd_q.delete();
      #1;
      chk("midrst_req_ready", bus.req_ready_o, 1);
      begin
         int d0;
         d0 = done_cnt;
         cmd_seen = 0;
         repeat (10) cycle();
         chk("midrst_no_done", done_cnt - d0, 0);
         chk("midrst_no_cmd", cmd_seen, 0);
      end
      $display("txn reset mid-write checked");

      // Sequencer still usable after the reset
      run_txn(tbl[6], 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
